// File: rtl/exe_div_unit_if.sv
// ---------------------------------------------------------------------------
// exe_div_unit_if
// Bundles the EXE-stage divider request/response signals.
//   master : pipeline side (ID/EXE registers, hazard unit, HI/LO writeback)
//   slave  : divider side
// Signals:
//   start     - divide request (registered is_div)
//   is_sign   - 1 = signed divide
//   dividend  - rs operand
//   divisor   - rt operand
//   cancel    - flush of the EXE instruction
//   hold      - downstream stall, EXE cannot advance
//   stall_req - divider requests a pipeline stall
//   done      - result valid this cycle
//   quotient  - result for LO
//   remainder - result for HI
// ---------------------------------------------------------------------------
interface exe_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic              is_sign;
  logic [DATA_W-1:0] dividend;
  logic [DATA_W-1:0] divisor;
  logic              cancel;
  logic              hold;
  logic              stall_req;
  logic              done;
  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;

  modport master (
    output start, is_sign, dividend, divisor, cancel, hold,
    input  stall_req, done, quotient, remainder
  );

  modport slave (
    input  start, is_sign, dividend, divisor, cancel, hold,
    output stall_req, done, quotient, remainder
  );
endinterface

// File: rtl/exe_div_unit.sv
// ---------------------------------------------------------------------------
// exe_div_unit
// Iterative radix-2 restoring divider for the EXE stage. Accepts a request
// from the ID/EXE registers, holds the pipeline via stall_req while it
// iterates one quotient bit per cycle, then presents quotient (LO) and
// remainder (HI) with done=1 until the pipeline advances.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous active-high reset
//   div_if - exe_div_unit_if.slave (request operands, cancel/hold in;
//            stall_req, done, quotient, remainder out)
// ---------------------------------------------------------------------------
module exe_div_unit #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic           clk,
  input  logic           rst,
  exe_div_unit_if.slave  div_if
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DIV0 = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;

  // r_dvd starts as the dividend magnitude; its MSB feeds the partial
  // remainder each step while quotient bits enter at the LSB, so after
  // DATA_W steps it holds the unsigned quotient.
  logic [DATA_W-1:0] r_dvd;
  logic [DATA_W-1:0] r_dvs;
  logic [DATA_W-1:0] r_prem;
  logic              r_q_neg;
  logic              r_r_neg;
  logic [DATA_W-1:0] r_quotient;
  logic [DATA_W-1:0] r_remainder;

  logic              w_accept;
  logic              w_last;
  logic [DATA_W:0]   w_shift;
  logic [DATA_W:0]   w_diff;
  logic              w_qbit;
  logic [DATA_W-1:0] w_rem_nxt;
  logic [DATA_W-1:0] w_quo_nxt;
  logic              w_stall_req;
  logic              w_done;

  // Magnitude of a two's complement operand when signed, raw otherwise.
  // The most negative value maps onto itself, which is its correct
  // unsigned magnitude.
  function automatic logic [DATA_W-1:0] mag(input logic signed [DATA_W-1:0] v,
                                            input logic                      sgn);
    return (sgn && v[DATA_W-1]) ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] cond_neg(input logic [DATA_W-1:0] v,
                                                 input logic              neg);
    return neg ? (-v) : v;
  endfunction

  assign w_accept = div_if.start & ~div_if.cancel;
  assign w_last   = (r_cnt == CNT_W'(DATA_W - 1));

  // One restoring step. The partial remainder is always below the divisor,
  // so the shifted value fits DATA_W+1 bits and the sign of the trial
  // difference is its top bit.
  always_comb begin
    w_shift   = {r_prem, r_dvd[DATA_W-1]};
    w_diff    = w_shift - {1'b0, r_dvs};
    w_qbit    = ~w_diff[DATA_W];
    w_rem_nxt = w_qbit ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
    w_quo_nxt = {r_dvd[DATA_W-2:0], w_qbit};
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and status outputs
  always_comb begin
    w_state_nxt = r_state;
    w_stall_req = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = (div_if.divisor == '0) ? DIV0 : BUSY;
        end
      end
      BUSY: begin
        if (div_if.cancel) begin
          w_state_nxt = IDLE;
        end else if (w_last) begin
          w_state_nxt = DONE;
        end
      end
      DIV0: begin
        w_state_nxt = div_if.cancel ? IDLE : DONE;
      end
      DONE: begin
        // Staying here under hold keeps the still-asserted start of the
        // same instruction from being taken as a new request.
        if (div_if.cancel || !div_if.hold) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_stall_req = w_accept & (r_state != DONE);
    w_done      = (r_state == DONE);
  end

  // Iteration counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (r_state == IDLE && w_accept) begin
      r_cnt <= '0;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Operand latch and iteration datapath
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_accept) begin
      // On the divide-by-zero path r_dvd keeps the raw dividend, which
      // becomes the remainder.
      r_dvd   <= (div_if.divisor == '0) ? div_if.dividend
                                         : mag(div_if.dividend, div_if.is_sign);
      r_dvs   <= mag(div_if.divisor, div_if.is_sign);
      r_q_neg <= div_if.is_sign & (div_if.dividend[DATA_W-1] ^ div_if.divisor[DATA_W-1]);
      r_r_neg <= div_if.is_sign & div_if.dividend[DATA_W-1];
      r_prem  <= '0;
    end else if (r_state == BUSY) begin
      r_dvd  <= w_quo_nxt;
      r_prem <= w_rem_nxt;
    end
  end

  // Result registers, written only on entry to DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      r_quotient  <= '0;
      r_remainder <= '0;
    end else if (r_state == BUSY && !div_if.cancel && w_last) begin
      r_quotient  <= cond_neg(w_quo_nxt, r_q_neg);
      r_remainder <= cond_neg(w_rem_nxt, r_r_neg);
    end else if (r_state == DIV0 && !div_if.cancel) begin
      r_quotient  <= '1;
      r_remainder <= r_dvd;
    end
  end

  assign div_if.stall_req = w_stall_req;
  assign div_if.done      = w_done;
  assign div_if.quotient  = r_quotient;
  assign div_if.remainder = r_remainder;

endmodule

// File: doc/exe_div_unit.md
Name: exe_div_unit

Overview:
- Iterative radix-2 divider in the EXE stage, directly downstream of the ID/EXE pipeline registers.
- Consumes the registered div-request, signedness and the two register-file operands from ID/EXE.
- Produces the quotient (to LO) and remainder (to HI) after a fixed multi-cycle latency.
- Requests an ID/EXE (and upstream) stall from the hazard unit until the result is ready.

Parameters:
- DATA_W, 32, operand/result width; iteration count equals DATA_W.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > DATA_W.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  divide request (registered is_div from ID/EXE).
- is_sign  input  1  1 = signed divide, 0 = unsigned (registered is_sign_div from ID/EXE).
- dividend  input  DATA_W  rs operand (forwarded rf_rdata0).
- divisor  input  DATA_W  rt operand (forwarded rf_rdata1).
- cancel  input  1  exception/flush of the EXE instruction; aborts the operation.
- hold  input  1  downstream stall; the EXE instruction cannot advance this cycle.
- stall_req  output  1  divider requests a pipeline stall.
- done  output  1  result valid this cycle.
- quotient  output  DATA_W  quotient, for LO.
- remainder  output  DATA_W  remainder, for HI.

Behaviour:
- States: IDLE, BUSY, DIV0, DONE.
- Reset (rst=1 at a clock edge): state=IDLE, counter=0, quotient=0, remainder=0, done=0. Reset takes effect from any state, including mid-BUSY.
- stall_req is combinational: start & ~cancel & (state != DONE). It is 0 in DONE.
- done = (state == DONE).

IDLE:
- start & ~cancel & divisor==0 -> DIV0.
- start & ~cancel & divisor!=0 -> BUSY. On entry:
  - Latch |dividend| and |divisor|. Absolute values are taken only when is_sign=1; raw values otherwise.
  - Latch quotient sign = is_sign & (dividend[MSB] ^ divisor[MSB]).
  - Latch remainder sign = is_sign & dividend[MSB].
  - counter=0; partial remainder=0.
- Otherwise stay in IDLE.

BUSY:
- Each cycle runs one restoring step on a (DATA_W+1)-bit partial remainder:
  - Shift in the next dividend MSB.
  - Trial-subtract the divisor.
  - Quotient bit = 1 if the result is non-negative; restore otherwise.
- counter increments each step. After step DATA_W (counter == DATA_W-1 at the edge) -> DONE.
- On the DONE entry edge, sign-correct the outputs:
  - quotient negated if the quotient sign is set;
  - remainder negated if the remainder sign is set.
- cancel=1 in BUSY -> IDLE next edge; outputs unchanged; done never asserted.

DIV0:
- One cycle, then -> DONE with quotient = all ones and remainder = dividend (latched raw).
- cancel -> IDLE.

DONE:
- Outputs held stable.
- hold=1 -> stay in DONE. This prevents re-issuing the same instruction while start is still high.
- hold=0 -> IDLE. A new start may be accepted on the following cycle.
- cancel -> IDLE.

Latency:
- Start accepted at edge 0. DONE is reached DATA_W+1 cycles after the start cycle.
- stall_req is high for DATA_W+1 cycles (33 for the default width) and drops in the DONE cycle.
- DIV0: stall_req high for 2 cycles.

Edge cases:
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF gives quotient 0x8000_0000, remainder 0, with no exception.
- Operand changes on the inputs while in BUSY are ignored; operands are latched.
- cancel and start high in the same IDLE cycle: no start.

Test Plan:
- Unsigned 100/7: start=1, is_sign=0 -> stall_req high 33 cycles; then done=1, quotient=14, remainder=2.
- Signed -7/2 (0xFFFF_FFF9 / 0x2) -> quotient=0xFFFF_FFFD, remainder=0xFFFF_FFFF. Also check 7/-2 -> quotient=0xFFFF_FFFD, remainder=1.
- Signed 0x8000_0000 / 0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0. Unsigned 0xFFFF_FFFF/1 -> quotient=0xFFFF_FFFF, remainder=0.
- Divide by zero: dividend=0x1234, divisor=0 -> done on the 3rd cycle (2 stall cycles), quotient=0xFFFF_FFFF, remainder=0x1234.
- cancel asserted at BUSY cycle 10 -> IDLE next edge, stall_req=0, done never pulses. A new start of 9/3 afterwards -> quotient=3, remainder=0.
- hold=1 for 3 cycles at DONE -> done and outputs stable for 4 cycles, no restart; reset mid-BUSY -> IDLE, all outputs 0 next cycle.
